// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared state encoding and slice width for the nibble-serial add/subtract unit.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// Combinational 4-bit ripple-carry slice; c3 is the carry into the top bit for overflow detection.
module add4_cin
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE-1:0] x,
  input  logic [NIBBLE-1:0] y,
  input  logic              ci,
  output logic [NIBBLE-1:0] s,
  output logic              co,
  output logic              c3
);

  logic [NIBBLE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < NIBBLE; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[NIBBLE];
    c3 = c[NIBBLE-1];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract unit that time-shares one 4-bit slice, one nibble per clock, LSB first,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / NIBBLE;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
    $fatal(1, "nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;

  logic [NIBBLE-1:0] slice_s;
  logic              slice_co;
  logic              slice_c3;
  logic [WIDTH-1:0]  a_d;
  logic              last_nib;

  add4_cin u_slice (
    .x  (a_q[NIBBLE-1:0]),
    .y  (b_q[NIBBLE-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // The A shift register doubles as the result register: each slice sum enters the
  // nibble that A just vacated at the top, so after NIB shifts it holds the full result.
  if (NIB == 1) begin : g_a_one
    assign a_d = slice_s;
  end else begin : g_a_many
    assign a_d = {slice_s, a_q[WIDTH-1:NIBBLE]};
  end

  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= op_sub ? ~b : b;
            carry_q    <= op_sub ? 1'b1 : cin;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q     <= a_d;
          b_q     <= b_q >> NIBBLE;
          carry_q <= slice_co;
          if (last_nib) begin
            state_q     <= ST_DONE;
            sum_q       <= a_d;
            cout_q      <= slice_co;
            ovf_q       <= slice_c3 ^ slice_co;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation in IDLE and returns edges from accept until out_valid (bounded).
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tcin, input logic tsub, output int lat);
    check("in_ready_before_issue", in_ready, 1);
    a = ta; b = tb_v; cin = tcin; op_sub = tsub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    int t, nacc, nres;
    bit acc_now;
    int acc_t[3];
    logic [WIDTH-1:0] ba[3], bb[3], rs[3];
    logic bc[3], bs[3], rc[3];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);

    issue(16'h1234, 16'h0FCD, 1'b0, 1'b0, lat);
    check("add_latency", lat, 4);
    check("add_sum", sum, 16'h2201);
    check("add_cout", cout, 0);
    check("add_ovf", ovf, 0);
    check("done_busy", busy, 1);
    check("done_in_ready", in_ready, 0);
    step();
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("sum_kept_after_done", sum, 16'h2201);

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("wrap_sum", sum, 16'h0000);
    check("wrap_cout", cout, 1);
    check("wrap_ovf", ovf, 0);
    step();

    issue(16'h0000, 16'h0000, 1'b1, 1'b0, lat);
    check("cin_sum", sum, 16'h0001);
    check("cin_cout", cout, 0);
    step();

    issue(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    check("sub_sum", sum, 16'hFFFE);
    check("sub_cout", cout, 0);
    check("sub_ovf", ovf, 0);
    step();

    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    check("povf_sum", sum, 16'h8000);
    check("povf_cout", cout, 0);
    check("povf_ovf", ovf, 1);
    step();

    issue(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    check("novf_sum", sum, 16'h7FFF);
    check("novf_cout", cout, 1);
    check("novf_ovf", ovf, 1);
    step();

    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 16'h3333);
    end
    check("bp_cout", cout, 0);
    check("bp_ovf", ovf, 0);
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_sum", sum, 16'h3333);

    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("abort_no_result", seen, 0);

    ba[0] = 16'h0001; bb[0] = 16'h0002; bc[0] = 1'b0; bs[0] = 1'b0;
    ba[1] = 16'h1000; bb[1] = 16'h0001; bc[1] = 1'b0; bs[1] = 1'b1;
    ba[2] = 16'hABCD; bb[2] = 16'h1111; bc[2] = 1'b1; bs[2] = 1'b0;
    nacc = 0; nres = 0; t = 0;
    a = ba[0]; b = bb[0]; cin = bc[0]; op_sub = bs[0]; in_valid = 1'b1;
    while (nres < 3 && t < 60) begin
      acc_now = in_valid && in_ready;
      step();
      t++;
      if (acc_now && nacc < 3) begin
        acc_t[nacc] = t;
        nacc++;
        if (nacc < 3) begin
          a = ba[nacc]; b = bb[nacc]; cin = bc[nacc]; op_sub = bs[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        rs[nres] = sum; rc[nres] = cout;
        nres++;
      end
    end
    in_valid = 1'b0;
    check("b2b_results", nres, 3);
    check("b2b_accepts", nacc, 3);
    // Each issue slot spans NIB RUN cycles plus one DONE and one IDLE cycle.
    check("b2b_spacing_01", acc_t[1] - acc_t[0], 6);
    check("b2b_spacing_12", acc_t[2] - acc_t[1], 6);
    check("b2b_sum0", rs[0], 16'h0003);
    check("b2b_cout0", rc[0], 0);
    check("b2b_sum1", rs[1], 16'h0FFF);
    check("b2b_cout1", rc[1], 1);
    check("b2b_sum2", rs[2], 16'hBCDF);
    check("b2b_cout2", rc[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
